// File: rtl/des_key_sched_if.sv
// Purpose : handshake/bus bundle between a DES key-schedule producer and its consumer.
// Latency : n/a (signal bundle only).
// Backpressure: subkey_ready from the consumer stalls subkey_valid/subkey_out/round_idx.
//
// Signals: start/decrypt/key_in load a key; subkey_out/subkey_valid/subkey_ready/round_idx
// carry one round key per handshake; busy/done/parity_err report status.
// slave = key-schedule side, master = side that loads keys and consumes subkeys.
interface des_key_sched_if #(
    parameter int RND_W = 5
);
    logic             start;
    logic             decrypt;
    logic [1:64]      key_in;
    logic [1:48]      subkey_out;
    logic             subkey_valid;
    logic             subkey_ready;
    logic [RND_W-1:0] round_idx;
    logic             busy;
    logic             done;
    logic             parity_err;

    modport master (
        output start, decrypt, key_in, subkey_ready,
        input  subkey_out, subkey_valid, round_idx, busy, done, parity_err
    );

    modport slave (
        input  start, decrypt, key_in, subkey_ready,
        output subkey_out, subkey_valid, round_idx, busy, done, parity_err
    );
endinterface

// File: rtl/des_key_sched.sv
// Purpose : sequential DES key schedule, one 48-bit round key per valid/ready handshake.
// Latency : first subkey valid the cycle after start is sampled; then one per cycle.
// Backpressure: subkey_ready low holds subkey_out/round_idx/subkey_valid stable indefinitely.
//
// Ports: clk, rst (synchronous, active high); bus (des_key_sched_if.slave):
//   start/decrypt/key_in sampled in IDLE; subkey_out/subkey_valid/subkey_ready/round_idx
//   carry the schedule (K1..K16 encrypt, K16..K1 decrypt); busy high outside IDLE;
//   done pulses one cycle after the last accepted subkey; parity_err see below.
// Build option: define DES_KEY_PARITY_CHECK_EN to reject keys with any even-parity byte
//   (one-cycle parity_err pulse, stays IDLE). Undefined: parity bits ignored, parity_err = 0.
module des_key_sched #(
    parameter int NUM_ROUNDS = 16,
    parameter int RND_W      = 5
) (
    input  logic           clk,
    input  logic           rst,
    des_key_sched_if.slave bus
);

    typedef enum logic {IDLE, GEN} state_t;

    // PC1: 64-bit key -> 56-bit C||D, DES bit numbering (1 = MSB).
    localparam int PC1_T [1:56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // PC2: 56-bit C||D -> 48-bit round key.
    localparam int PC2_T [1:48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [1:56] pc1(input logic [1:64] k);
        logic [1:56] p;
        for (int i = 1; i <= 56; i++) begin
            p[i] = k[PC1_T[i]];
        end
        return p;
    endfunction

    function automatic logic [1:48] pc2(input logic [1:56] cd);
        logic [1:48] p;
        for (int i = 1; i <= 48; i++) begin
            p[i] = cd[PC2_T[i]];
        end
        return p;
    endfunction

    // Rounds 1, 2, 9 and 16 shift by one; every other round shifts by two.
    function automatic logic is_double(input logic [RND_W-1:0] r);
        return !((r == RND_W'(1)) || (r == RND_W'(2)) ||
                 (r == RND_W'(9)) || (r == RND_W'(16)));
    endfunction

    // C and D are rotated as independent 28-bit halves.
    function automatic logic [1:56] rotl_cd(input logic [1:56] cd, input logic two);
        logic [1:28] c;
        logic [1:28] d;
        c = cd[1:28];
        d = cd[29:56];
        if (two) begin
            return {c[3:28], c[1:2], d[3:28], d[1:2]};
        end
        return {c[2:28], c[1], d[2:28], d[1]};
    endfunction

    function automatic logic [1:56] rotr_cd(input logic [1:56] cd, input logic two);
        logic [1:28] c;
        logic [1:28] d;
        c = cd[1:28];
        d = cd[29:56];
        if (two) begin
            return {c[27:28], c[1:26], d[27:28], d[1:26]};
        end
        return {c[28], c[1:27], d[28], d[1:27]};
    endfunction

    state_t           state_q, state_d;
    logic [1:56]      cd_q, cd_d;
    logic [RND_W-1:0] cnt_q, cnt_d;
    logic             dec_q, dec_d;
    logic             done_q, done_d;
    logic             key_ok;
    logic             hs;
    logic             last;
    logic [RND_W-1:0] enc_rnd;   // round whose shift is applied next when encrypting
    logic [RND_W-1:0] dec_rnd;   // round number currently presented when decrypting

`ifdef DES_KEY_PARITY_CHECK_EN
    logic perr_q, perr_d;

    // Every byte of the key must carry odd parity.
    always_comb begin
        key_ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (!(^bus.key_in[8*b+1 +: 8])) begin
                key_ok = 1'b0;
            end
        end
    end
`else
    assign key_ok = 1'b1;
`endif

    assign hs      = (state_q == GEN) && bus.subkey_ready;
    assign last    = (cnt_q == RND_W'(NUM_ROUNDS));
    assign enc_rnd = cnt_q + RND_W'(1);
    assign dec_rnd = RND_W'(17) - cnt_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cd_q    <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
`ifdef DES_KEY_PARITY_CHECK_EN
            perr_q  <= perr_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (key_ok) begin
                        state_d = GEN;
                        dec_d   = bus.decrypt;
                        cnt_d   = RND_W'(1);
                        // Decrypt starts at K16: C16D16 equals C0D0, so no shift.
                        cd_d    = bus.decrypt ? pc1(bus.key_in)
                                              : rotl_cd(pc1(bus.key_in), 1'b0);
                    end
`ifdef DES_KEY_PARITY_CHECK_EN
                    else begin
                        perr_d = 1'b1;
                    end
`endif
                end
            end
            GEN: begin
                if (hs) begin
                    if (last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + RND_W'(1);
                        // Decrypt undoes the shift of the round just delivered.
                        cd_d  = dec_q ? rotr_cd(cd_q, is_double(dec_rnd))
                                      : rotl_cd(cd_q, is_double(enc_rnd));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.subkey_valid = (state_q == GEN);
        bus.busy         = (state_q == GEN);
        bus.subkey_out   = pc2(cd_q);
        bus.done         = done_q;
        bus.round_idx    = '0;
        if (state_q == GEN) begin
            bus.round_idx = dec_q ? dec_rnd : cnt_q;
        end
`ifdef DES_KEY_PARITY_CHECK_EN
        bus.parity_err   = perr_q;
`else
        bus.parity_err   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_des_key_sched.sv
// Purpose : self-checking bench for des_key_sched against a table-driven DES key-schedule model.
// Latency : checks first subkey the cycle after start, one per cycle when ready is held high.
// Backpressure: random subkey_ready stalls; outputs must hold until accepted.
module tb_des_key_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    des_key_sched_if #(.RND_W(5)) bus ();

    des_key_sched #(.NUM_ROUNDS(16), .RND_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam int PC1_M [1:56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_M [1:48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    int n_chk  = 0;
    int n_fail = 0;

    // Round key r computed directly: after r rounds each half has rotated left by the
    // cumulative shift total, so bit k of C_r is bit (k+t mod 28) of C_0.
    function automatic logic [47:0] model_sk(input logic [63:0] key, input int r);
        int t;
        int p;
        int src;
        logic [47:0] o;
        t = 0;
        for (int j = 1; j <= r; j++) t += SHIFTS[j];
        o = '0;
        for (int k = 1; k <= 48; k++) begin
            p = PC2_M[k];
            if (p <= 28) src = ((p - 1 + t) % 28) + 1;
            else         src = 28 + ((p - 29 + t) % 28) + 1;
            o[48-k] = key[64 - PC1_M[src]];
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stream and observation state shared with the compare process.
    logic [47:0] exp_sk[$];
    int          exp_idx[$];
    bit          checking  = 1'b0;
    bit          done_due  = 1'b0;
    bit          first_seen;
    logic [47:0] first_sk;
    int          first_idx;
    logic [47:0] last_sk;
    int          last_idx;
    int          acc_cnt;

    always @(negedge clk) begin
        bit pop_last;
        pop_last = 1'b0;
        if (!rst && checking) begin
            if (bus.subkey_valid) begin
                if (exp_sk.size() == 0) begin
                    chk("unexpected_valid", 64'(bus.subkey_valid), 64'd0);
                end else begin
                    chk("subkey", 64'(bus.subkey_out), 64'(exp_sk[0]));
                    chk("round_idx", 64'(bus.round_idx), 64'(exp_idx[0]));
                    chk("busy_in_gen", 64'(bus.busy), 64'd1);
                    if (!first_seen) begin
                        first_seen = 1'b1;
                        first_sk   = bus.subkey_out;
                        first_idx  = int'(bus.round_idx);
                    end
                    if (bus.subkey_ready) begin
                        last_sk  = bus.subkey_out;
                        last_idx = int'(bus.round_idx);
                        void'(exp_sk.pop_front());
                        void'(exp_idx.pop_front());
                        acc_cnt++;
                        pop_last = (exp_sk.size() == 0);
                    end
                end
            end
            chk("done", 64'(bus.done), 64'(done_due));
`ifndef DES_KEY_PARITY_CHECK_EN
            chk("parity_err_tied", 64'(bus.parity_err), 64'd0);
`endif
            done_due = pop_last;
        end
    end

    // One key load: queue the model's schedule, pulse start, drive ready, wait for done.
    task automatic run(input logic [63:0] key, input logic dec, input bit rnd_rdy,
                       input int abort_after, input logic [47:0] first_exp,
                       input logic [47:0] last_exp);
        bit finished;
        int r;
        for (int n = 1; n <= 16; n++) begin
            r = dec ? 17 - n : n;
            exp_sk.push_back(model_sk(key, r));
            exp_idx.push_back(r);
        end
        acc_cnt    = 0;
        first_seen = 1'b0;
        finished   = 1'b0;
        bus.key_in       = key;
        bus.decrypt      = dec;
        bus.start        = 1'b1;
        bus.subkey_ready = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("first_valid_latency", 64'(bus.subkey_valid), 64'd1);
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            if (rnd_rdy) begin
                bus.subkey_ready = ($urandom_range(0, 2) != 0);
                // Stray start/decrypt while busy must be ignored.
                bus.start   = bus.busy && ($urandom_range(0, 3) == 0);
                bus.decrypt = 1'($urandom_range(0, 1));
                bus.key_in  = 64'hFFFF_0000_FFFF_0000;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (abort_after > 0 && acc_cnt >= abort_after) begin
                rst = 1'b1;
                bus.subkey_ready = 1'b0;
                exp_sk.delete();
                exp_idx.delete();
                @(posedge clk); #1;
                chk("rst_busy", 64'(bus.busy), 64'd0);
                chk("rst_valid", 64'(bus.subkey_valid), 64'd0);
                chk("rst_done", 64'(bus.done), 64'd0);
                chk("rst_accepted", 64'(acc_cnt), 64'd5);
                rst = 1'b0;
                chk("first_subkey", 64'(first_sk), 64'(first_exp));
                return;
            end
            if (bus.done) finished = 1'b1;
        end
        chk("done_within_budget", 64'(finished), 64'd1);
        chk("busy_after_done", 64'(bus.busy), 64'd0);
        chk("accepted_count", 64'(acc_cnt), 64'd16);
        chk("first_subkey", 64'(first_sk), 64'(first_exp));
        chk("first_idx", 64'(first_idx), dec ? 64'd16 : 64'd1);
        chk("last_subkey", 64'(last_sk), 64'(last_exp));
        chk("last_idx", 64'(last_idx), dec ? 64'd1 : 64'd16);
        bus.subkey_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    localparam logic [63:0] KEY  = 64'h1334_5779_9BBC_DFF1;
    localparam logic [47:0] K1   = 48'h1B02_EFFC_7072;
    localparam logic [47:0] K16  = 48'hCB3D_8B0E_17F5;
    localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;

    initial begin
        bus.start        = 1'b0;
        bus.decrypt      = 1'b0;
        bus.key_in       = '0;
        bus.subkey_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 64'(bus.subkey_valid), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_parity_err", 64'(bus.parity_err), 64'd0);
        chk("reset_round_idx", 64'(bus.round_idx), 64'd0);
        chk("reset_subkey", 64'(bus.subkey_out), 64'd0);
        rst = 1'b0;

        // Pin the model to known textbook and weak-key values.
        chk("model_k1", 64'(model_sk(KEY, 1)), 64'(K1));
        chk("model_k16", 64'(model_sk(KEY, 16)), 64'(K16));
        chk("model_weak0", 64'(model_sk(64'h0101_0101_0101_0101, 7)), 64'd0);
        chk("model_weak1", 64'(model_sk(64'hFEFE_FEFE_FEFE_FEFE, 9)), 64'(ONES));

        @(posedge clk); #1;
        checking = 1'b1;

        run(KEY, 1'b0, 1'b0, 0, K1, K16);
        run(KEY, 1'b1, 1'b0, 0, K16, K1);
        run(KEY, 1'b0, 1'b1, 0, K1, K16);
        run(64'h0101_0101_0101_0101, 1'b0, 1'b0, 0, 48'd0, 48'd0);
        run(64'h0101_0101_0101_0101, 1'b1, 1'b0, 0, 48'd0, 48'd0);
        run(64'hFEFE_FEFE_FEFE_FEFE, 1'b0, 1'b0, 0, ONES, ONES);
        run(64'hFEFE_FEFE_FEFE_FEFE, 1'b1, 1'b1, 0, ONES, ONES);
        run(KEY, 1'b0, 1'b0, 5, K1, K16);
        run(KEY, 1'b0, 1'b0, 0, K1, K16);

`ifdef DES_KEY_PARITY_CHECK_EN
        bus.key_in  = 64'h0;
        bus.decrypt = 1'b0;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("perr_pulse", 64'(bus.parity_err), 64'd1);
        chk("perr_busy", 64'(bus.busy), 64'd0);
        chk("perr_valid", 64'(bus.subkey_valid), 64'd0);
        @(posedge clk); #1;
        chk("perr_one_cycle", 64'(bus.parity_err), 64'd0);
        chk("perr_still_idle", 64'(bus.subkey_valid), 64'd0);
        run(KEY, 1'b0, 1'b0, 0, K1, K16);
`else
        run(64'h0, 1'b0, 1'b0, 0, 48'd0, 48'd0);
`endif

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
